// File: rtl/mem_copy_pkg.sv
// Shared types and width helpers for the mem_copy_dma block.
// The optional fill feature is enabled with the MEM_COPY_FILL_EN macro (see mem_copy_dma.sv).
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_FIFO_DEPTH = 4;

  // Pointer width for a power-of-2 FIFO; at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_copy_fifo.sv
// Synchronous read-data buffer for mem_copy_dma: push/pop with occupancy count.
// Combinational read of the head entry; caller guarantees no push when full, no pop when empty.
module mem_copy_fifo
  import mem_copy_pkg::*;
#(
  parameter int DLEN  = 8,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DLEN-1:0] din,
  input  logic            pop,
  output logic [DLEN-1:0] dout,
  output logic [CW-1:0]   count,
  output logic            empty
);

  logic [DLEN-1:0] store_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      if (push) begin
        store_q[wr_ptr_q] <= din;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = store_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_copy_dma.sv
// Memory-to-memory copy engine: one read and one write per cycle through a credit-limited buffer.
// Define MEM_COPY_FILL_EN to add constant-fill mode (fill_mode/fill_data); otherwise those inputs are ignored.
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int ALEN       = 8,
  parameter int DLEN       = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ALEN-1:0] src,
  input  logic [ALEN-1:0] dst,
  input  logic [ALEN:0]   len,
  input  logic [DLEN-1:0] fill_data,
  input  logic            fill_mode,
  output logic            busy,
  output logic            done,
  output logic            mem_wen,
  output logic [ALEN-1:0] mem_waddr,
  output logic [DLEN-1:0] mem_wdata,
  output logic            mem_ren,
  output logic [ALEN-1:0] mem_raddr,
  input  logic [DLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output state_e          dbg_state
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  // Memory handshake: a request is issued in every cycle mem_ren/mem_wen is high (no ready
  // back-pressure); read data is accepted in every cycle mem_rvalid is high, in request order.

  state_e          state_q, state_d;
  logic [ALEN-1:0] src_q, dst_q;
  logic [ALEN:0]   len_q, rd_cnt_q, wr_cnt_q;
  logic [CW-1:0]   inflight_q;
  logic            fill_q;
  logic [DLEN-1:0] fill_word_q;

  logic            rd_issue, wr_issue, push, pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [DLEN-1:0] fifo_dout;
  logic [CW:0]     credit_used;

  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign push        = (state_q == RUN) && mem_rvalid;
  assign pop         = wr_issue && !fill_q;

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        rd_issue = !fill_q && (rd_cnt_q < len_q) && (credit_used < DEPTH_L);
        wr_issue = (wr_cnt_q < len_q) && (fill_q || !fifo_empty);
        // Leave RUN together with the last write so done lines up with it.
        if (wr_issue && ((wr_cnt_q + (ALEN+1)'(1)) == len_q)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= '0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      mem_ren <= rd_issue;
      mem_wen <= wr_issue;
      if (state_q == IDLE && start) begin
        src_q    <= src;
        dst_q    <= dst;
        len_q    <= len;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end
      if (rd_issue) begin
        mem_raddr <= src_q + rd_cnt_q[ALEN-1:0];
        rd_cnt_q  <= rd_cnt_q + (ALEN+1)'(1);
      end
      if (wr_issue) begin
        mem_waddr <= dst_q + wr_cnt_q[ALEN-1:0];
        mem_wdata <= fill_q ? fill_word_q : fifo_dout;
        wr_cnt_q  <= wr_cnt_q + (ALEN+1)'(1);
      end
      if (state_q != RUN) begin
        inflight_q <= '0;
      end else begin
        case ({rd_issue, push})
          2'b10:   inflight_q <= inflight_q + CW'(1);
          2'b01:   inflight_q <= inflight_q - CW'(1);
          default: inflight_q <= inflight_q;
        endcase
      end
    end
  end

`ifdef MEM_COPY_FILL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_word_q <= '0;
    end else if (state_q == IDLE && start) begin
      fill_q      <= fill_mode;
      fill_word_q <= fill_data;
    end
  end
`else
  logic unused_fill;
  assign fill_q      = 1'b0;
  assign fill_word_q = '0;
  assign unused_fill = ^{fill_data, fill_mode};
`endif

  mem_copy_fifo #(
    .DLEN (DLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (mem_rdata),
    .pop  (pop),
    .dout (fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: behavioural memory responder with selectable read latency,
// a sequential copy model producing expected read/write streams, and a per-cycle compare process.
module tb_mem_copy_dma;
  import mem_copy_pkg::*;

  localparam int ALEN  = 8;
  localparam int DLEN  = 8;
  localparam int DEPTH = 4;
  localparam int MSZ   = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start, fill_mode;
  logic [ALEN-1:0] src, dst;
  logic [ALEN:0]   len;
  logic [DLEN-1:0] fill_data;
  logic            busy, done, mem_wen, mem_ren, mem_rvalid;
  logic [ALEN-1:0] mem_waddr, mem_raddr;
  logic [DLEN-1:0] mem_wdata, mem_rdata;
  state_e          dbg_state;

  mem_copy_dma #(.ALEN(ALEN), .DLEN(DLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .fill_data(fill_data), .fill_mode(fill_mode), .busy(busy), .done(done),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .dbg_state(dbg_state)
  );

  // memory responder: delay line, read captured when request is seen
  logic [7:0] mem [MSZ];
  logic [7:0] exp_mem [MSZ];
  logic       pv [4];
  logic [7:0] pd [4];
  int         lat = 1;
  logic       pre_we = 1'b0, pre_rand = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pv[i] <= pv[i+1];
      pd[i] <= pd[i+1];
    end
    pv[3] <= 1'b0;
    pd[3] <= '0;
    if (mem_ren) begin
      pv[lat-1] <= 1'b1;
      pd[lat-1] <= mem[mem_raddr];
    end
    if (pre_rand) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= 8'($urandom);
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rvalid = pv[0];
  assign mem_rdata  = pd[0];

  // scoreboard
  int checks = 0, errors = 0;
  logic [15:0] exp_w [$];
  logic [7:0]  exp_r [$];
  bit active = 1'b0;
  int ren_seen, wen_seen, done_seen, cur_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (active && !rst) begin
      if (mem_ren) begin
        ren_seen++;
        if (exp_r.size() == 0) chk("unexpected_read", {24'd0, mem_raddr}, 32'hFFFF_FFFF);
        else chk("read_addr", {24'd0, mem_raddr}, {24'd0, exp_r.pop_front()});
      end
      if (mem_wen) begin
        wen_seen++;
        if (exp_w.size() == 0) chk("unexpected_write", {16'd0, mem_waddr, mem_wdata}, 32'hFFFF_FFFF);
        else chk("write_addr_data", {16'd0, mem_waddr, mem_wdata}, {16'd0, exp_w.pop_front()});
      end
      chk("outstanding_bound", 32'(ren_seen - wen_seen > DEPTH), 32'd0);
      if (done) begin
        done_seen++;
        chk("done_with_last_write", {30'd0, mem_wen, exp_w.size() == 0}, {30'd0, cur_len != 0, 1'b1});
      end
    end
  end

  // driver tasks
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_copy(input int s, input int d, input int l, input int lt,
                          input bit fm, input logic [7:0] fd, input bit mid);
    bit eff_fill;
    int t, bad;
    logic [7:0] a_s, a_d, v;
`ifdef MEM_COPY_FILL_EN
    eff_fill = fm;
`else
    eff_fill = 1'b0;
`endif
    lat = lt;
    for (int i = 0; i < MSZ; i++) exp_mem[i] = mem[i];
    exp_w.delete();
    exp_r.delete();
    for (int i = 0; i < l; i++) begin
      a_s = 8'((s + i) % MSZ);
      a_d = 8'((d + i) % MSZ);
      v   = eff_fill ? fd : exp_mem[a_s];
      exp_mem[a_d] = v;
      if (!eff_fill) exp_r.push_back(a_s);
      exp_w.push_back({a_d, v});
    end
    ren_seen = 0; wen_seen = 0; done_seen = 0; cur_len = l;
    active = 1'b1;
    start = 1'b1; src = 8'(s); dst = 8'(d); len = 9'(l); fill_mode = fm; fill_data = fd;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, {31'd0, l != 0});
    if (mid) begin
      @(posedge clk); #1;
      start = 1'b1; src = 8'h33; dst = 8'h77; len = 9'd0; fill_mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_seen == 0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_timeout", {31'd0, t < 3000}, 32'd1);
    repeat (6) @(negedge clk);
    #1;
    active = 1'b0;
    chk("done_pulse_count", 32'(done_seen), 32'd1);
    chk("writes_left", 32'(exp_w.size()), 32'd0);
    chk("reads_left", 32'(exp_r.size()), 32'd0);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    bad = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("memory_image", 32'(bad), 32'd0);
  endtask

  initial begin
    int s, l, d, t;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill_mode = 1'b0; fill_data = '0;
    pre_rand = 1'b1;
    @(posedge clk); #1;
    pre_rand = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {27'd0, busy, done, mem_wen, mem_ren, 1'b0},
        32'd0);
    chk("reset_addr_data", {8'd0, mem_waddr, mem_raddr, mem_wdata}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;

    // basic copy A0..A3 -> 4..7
    for (int i = 0; i < 4; i++) poke(8'(i), 8'hA0 + 8'(i));
    run_copy(0, 4, 4, 1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) chk("basic_literal", {24'd0, mem[4+i]}, {24'd0, 8'hA0 + 8'(i)});

    // len = 0
    run_copy(9, 40, 0, 1, 1'b0, 8'h00, 1'b0);
    chk("len0_no_access", 32'(ren_seen + wen_seen), 32'd0);

    // destination wrap, then source wrap
    for (int i = 0; i < 4; i++) poke(8'(20 + i), 8'hC0 + 8'(i));
    run_copy(20, 254, 4, 2, 1'b0, 8'h00, 1'b0);
    chk("dst_wrap_254", {24'd0, mem[254]}, 32'hC0);
    chk("dst_wrap_1", {24'd0, mem[1]}, 32'hC3);
    run_copy(254, 10, 4, 1, 1'b0, 8'h00, 1'b0);
    chk("src_wrap_10", {24'd0, mem[10]}, 32'hC0);
    chk("src_wrap_13", {24'd0, mem[13]}, 32'hC3);

    // 3-cycle latency with a start pulse ignored mid-run
    run_copy(40, 100, 8, 3, 1'b0, 8'h00, 1'b1);

    // fill mode (copy when the feature is compiled out)
    run_copy(60, 2, 3, 1, 1'b1, 8'h5A, 1'b0);
`ifdef MEM_COPY_FILL_EN
    chk("fill_no_reads", 32'(ren_seen), 32'd0);
    for (int i = 0; i < 3; i++) chk("fill_literal", {24'd0, mem[2+i]}, 32'h5A);
`else
    chk("fill_ignored_reads", 32'(ren_seen), 32'd3);
`endif

    // reset mid-run after two writes
    lat = 3;
    start = 1'b1; src = 8'd100; dst = 8'd150; len = 9'd20; fill_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (t < 200) begin
      @(negedge clk); #1;
      if (mem_wen) wen_seen++;
      if (wen_seen >= 2 + 0 && t > 0 && mem_wen && wen_seen >= 2) break;
      t++;
    end
    chk("rst_reach_two_writes", {31'd0, t < 200}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {28'd0, busy, done, mem_wen, mem_ren}, 32'd0);
    chk("rst_mid_addr_data", {8'd0, mem_waddr, mem_raddr, mem_wdata}, 32'd0);
    t = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || mem_ren || mem_wen || busy) t++;
    end
    chk("rst_mid_quiet", 32'(t), 32'd0);
    run_copy(100, 150, 20, 2, 1'b0, 8'h00, 1'b0);

    // randomized copies, non-overlapping regions
    for (int k = 0; k < 12; k++) begin
      l = $urandom_range(1, 60);
      s = $urandom_range(0, 255);
      d = (s + l + $urandom_range(0, 100)) % MSZ;
      run_copy(s, d, l, $urandom_range(1, 3), 1'b0, 8'h00, 1'b0);
    end

    // full memory copy onto itself
    run_copy(0, 0, 256, 2, 1'b0, 8'h00, 1'b0);
    chk("full_write_count", 32'(wen_seen), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
